// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch
// and load/store. A watchdog aborts any access that the memory never acknowledges.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  bus_err,
    output logic                  busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t        state_q, state_d;
    logic          last_data_q, last_data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic granted, ack_done, timeout;

    assign granted  = (state_q != IDLE);
    assign ack_done = granted && mem_ack;
    // A late ack in the final watchdog cycle still counts as a normal completion.
    assign timeout  = granted && !mem_ack && (cnt_q == CNT_MAX);

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (if_req && (!d_req || last_data_q)) begin
                    state_d     = FETCH;
                    last_data_d = 1'b0;
                    cnt_d       = '0;
                end else if (d_req) begin
                    state_d     = DATA;
                    last_data_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            FETCH, DATA: begin
                if (ack_done || timeout) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_data_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_done   = 1'b0;
        d_done    = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        case (state_q)
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = if_addr;
                if_done  = ack_done || timeout;
                if (ack_done) if_rdata = mem_rdata;
            end
            DATA: begin
                mem_req   = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_done    = ack_done || timeout;
                if (ack_done) d_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

    assign bus_err = timeout;
    assign busy    = granted;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter; the memory side is driven by hand.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .bus_err  (bus_err),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_outs", {27'd0, if_done, d_done, bus_err, mem_we, |mem_addr}, 32'd0);
        rst = 1'b0;

        // Fetch only, ack two cycles after mem_req rises
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        check("no_comb_req_path", {31'd0, mem_req}, 32'd0);
        step();
        check("f_mem_req_c1", {31'd0, mem_req}, 32'd1);
        check("f_mem_addr", mem_addr, 32'h100);
        check("f_mem_we", {31'd0, mem_we}, 32'd0);
        check("f_no_done_c1", {31'd0, if_done}, 32'd0);
        step();
        check("f_mem_req_c2", {31'd0, mem_req}, 32'd1);
        check("f_no_done_c2", {31'd0, if_done}, 32'd0);
        step();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        check("f_done_c3", {31'd0, if_done}, 32'd1);
        check("f_rdata", if_rdata, 32'hDEADBEEF);
        check("f_d_done", {31'd0, d_done}, 32'd0);
        check("f_d_rdata_zero", d_rdata, 32'd0);
        check("f_bus_err", {31'd0, bus_err}, 32'd0);
        if_req = 1'b0;
        step();
        mem_ack = 1'b0;
        check("f_busy_c4", {31'd0, busy}, 32'd0);

        // Store with zero-wait ack
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678;
        step();
        check("s_mem_req", {31'd0, mem_req}, 32'd1);
        check("s_mem_we", {31'd0, mem_we}, 32'd1);
        check("s_mem_addr", mem_addr, 32'h2000);
        check("s_mem_wdata", mem_wdata, 32'h12345678);
        mem_ack = 1'b1;
        #1;
        check("s_d_done", {31'd0, d_done}, 32'd1);
        check("s_if_done", {31'd0, if_done}, 32'd0);
        d_req = 1'b0;
        step();
        mem_ack = 1'b0;
        check("s_idle", {31'd0, busy}, 32'd0);

        // Load: read data routed to the data port only
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004;
        step();
        check("l_mem_we", {31'd0, mem_we}, 32'd0);
        check("l_mem_wdata", mem_wdata, 32'h12345678);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        check("l_d_rdata", d_rdata, 32'hCAFEF00D);
        check("l_if_rdata_zero", if_rdata, 32'd0);
        d_req = 1'b0;
        step();
        mem_ack = 1'b0;

        // Tie after reset: FETCH first, then alternating F, D, F, D
        rst = 1'b1; step(); rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("tie%0d_addr", i), mem_addr, (i % 2 == 0) ? 32'h300 : 32'h400);
            mem_ack = 1'b1;
            #1;
            check($sformatf("tie%0d_if_done", i), {31'd0, if_done}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("tie%0d_d_done", i), {31'd0, d_done}, (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            mem_ack = 1'b0;
            check($sformatf("tie%0d_turnaround", i), {31'd0, busy}, 32'd0);
        end
        if_req = 1'b0; d_req = 1'b0;
        step();
        check("tie_end_idle", {31'd0, busy}, 32'd0);

        // Timeout: no ack for 16 mem_req cycles
        if_req = 1'b1; if_addr = 32'h500; mem_rdata = 32'h55AA55AA;
        step();
        for (int i = 1; i < 16; i++) begin
            check($sformatf("to_wait%0d", i), {30'd0, if_done, bus_err}, 32'd0);
            step();
        end
        check("to_done", {31'd0, if_done}, 32'd1);
        check("to_bus_err", {31'd0, bus_err}, 32'd1);
        check("to_rdata_zero", if_rdata, 32'd0);
        if_req = 1'b0;
        step();
        check("to_idle", {30'd0, mem_req, bus_err}, 32'd0);

        // Ack in the last watchdog cycle wins
        if_req = 1'b1;
        step();
        for (int i = 1; i < 16; i++) step();
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        #1;
        check("at_done", {31'd0, if_done}, 32'd1);
        check("at_bus_err", {31'd0, bus_err}, 32'd0);
        check("at_rdata", if_rdata, 32'h0BADF00D);
        if_req = 1'b0;
        step();
        mem_ack = 1'b0;
        check("at_idle", {31'd0, busy}, 32'd0);

        // Reset while a load waits for ack
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        step();
        step();
        check("rm_waiting", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rm_mem_req", {31'd0, mem_req}, 32'd0);
        check("rm_no_done", {31'd0, d_done}, 32'd0);
        if_req = 1'b1; if_addr = 32'h700;
        step();
        check("rm_tie_fetch", mem_addr, 32'h700);
        // Counter must restart from zero: 15 silent cycles before the abort
        for (int i = 1; i < 16; i++) begin
            check($sformatf("rm_wait%0d", i), {31'd0, bus_err}, 32'd0);
            step();
        end
        check("rm_timeout", {31'd0, bus_err}, 32'd1);
        if_req = 1'b0; d_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported memory between the RISC-V core's instruction-fetch path and its load/store path. It sits between the core and a unified instruction/data memory. It serializes accesses, returns read data to the requester that issued them, and applies round-robin fairness. A watchdog aborts any access the memory never acknowledges.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- TIMEOUT, 16, maximum cycles a granted access waits for mem_ack (>=2)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req
- if_rdata  out  DATA_WIDTH  fetch data; valid only with if_done
- if_done  out  1  fetch completion strobe
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data; valid only with d_done
- d_done  out  1  data completion strobe
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data; valid in the mem_ack cycle
- mem_ack  in  1  one-cycle acknowledge from memory
- bus_err  out  1  watchdog-abort strobe, coincident with the done strobe
- busy  out  1  access in progress (state != IDLE)

## Operation
- States: IDLE, FETCH, DATA. Registers: state, last_grant (FETCH/DATA), cnt ($clog2(TIMEOUT) bits).
- IDLE:
  - Only d_req → DATA.
  - Only if_req → FETCH.
  - Both → grant the requester that is not last_grant.
  - Neither → stay in IDLE.
  - On every grant, last_grant <= grantee and cnt <= 0.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=if_addr, mem_wdata=0.
- DATA:
  - mem_req=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata.
- IDLE outputs: mem_req, mem_we, mem_addr and mem_wdata all 0.
- Completion (combinational): in FETCH/DATA, on mem_ack the grantee's done=1 and its rdata=mem_rdata. The next state is IDLE.
- rdata of a non-done requester is 0. A store's d_rdata is mem_rdata and is don't-care.
- Watchdog:
  - In FETCH/DATA, if mem_ack=0, cnt increments.
  - If mem_ack=0 and cnt==TIMEOUT-1: the grantee's done=1, bus_err=1, rdata=0, and the next state is IDLE.
  - mem_ack in the same cycle wins: normal completion, bus_err=0.
- Request dropped before done: the access runs to ack or timeout. The done strobe still fires and is ignored.
- Request address or data changing mid-access: the change passes straight through to mem_addr/mem_wdata. This is a protocol violation and the arbiter does not check for it.
- Reset values: state=IDLE, last_grant=DATA (first tie goes to FETCH), cnt=0. All outputs 0.

## Timing
- Request seen in IDLE at edge k → mem_req high in cycle k+1 (one-cycle grant latency).
- Memory acks n cycles after mem_req rises (n>=0) → done in the same cycle as mem_ack. Total latency is n+1 cycles from the request edge.
- After every completion, one mandatory IDLE turnaround cycle follows. Back-to-back accesses therefore start at most every n+2 cycles.
- Timeout fires with done/bus_err in the TIMEOUT-th cycle of mem_req. mem_req falls on the next edge.
- rst asserted mid-access: at that edge the state goes to IDLE. mem_req drops in the following cycle and no done is issued. The memory must tolerate an abandoned request.
- Outputs depend combinationally on state, mem_ack, mem_rdata and the request address/data. There is no combinational path from if_req/d_req to mem_req.

## Test plan
- Fetch only: if_req=1, if_addr=0x100, memory acks 2 cycles after mem_req with 0xDEADBEEF → mem_req from cycle 1, if_done=1 and if_rdata=0xDEADBEEF in cycle 3, busy=0 in cycle 4.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0x12345678, ack at 0 wait → mem_we=1, mem_addr=0x2000, mem_wdata=0x12345678, d_done in cycle 1.
- Tie after reset: if_req and d_req both raised in cycle 0 and held → FETCH served first, then DATA. With both kept asserted, grants alternate F, D, F, D.
- Timeout: TIMEOUT=16, if_req held, mem_ack never asserted → if_done=1, bus_err=1, if_rdata=0 in the 16th mem_req cycle. IDLE next.
- Ack coincides with timeout: mem_ack in cycle cnt==15 → if_done=1, bus_err=0, if_rdata=mem_rdata.
- Reset mid-access: rst pulsed while in DATA waiting for ack → state IDLE, mem_req=0 the next cycle, no d_done. The next tie is granted to FETCH.
